vip_frame_source: RTL

- Synthesizable video frame source that drives the VIP per_frame_* stream interface: vsync, href, clken and 24-bit RGB888 data.
- Produces programmable-size frames with blanking and one of four test patterns.
- Feeds rgb2ycbcr/sobel pipelines in place of the camera capture path, for bring-up and regression.
- Its outputs connect directly to a VIP block's pre_frame_vsync, per_frame_href, per_frame_clken and per_frame_data inputs.

---
 rtl/vip_frame_source.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vip_frame_source.sv
// Test-pattern frame source driving the VIP per_frame_* stream; outputs are registered one cycle after position decode.
// Latency: enable in IDLE -> vsync high 2 cycles later. No backpressure: pixels are paced only by the CLKEN_DIV tick.
module vip_frame_source #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 160,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 10,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int CLKEN_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [23:0] post_frame_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int V_ACT0  = V_SYNC + V_BP;
    localparam int V_ACT1  = V_ACT0 + V_ACTIVE;
    localparam int BW      = H_ACTIVE / 8;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLKEN_DIV + 1);
    localparam int BCW     = $clog2(BW + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [BCW-1:0]  bar_px_q, bar_px_d;
    logic [2:0]      bar_idx_q, bar_idx_d;
    logic [1:0]      pat_q, pat_d;
    logic [23:0]     solid_q, solid_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            vsync_q, href_q, clken_q, done_q;
    logic [23:0]     data_q;

    logic            running, tick, h_last, v_last, frame_end;
    logic            vsync_w, active_line, href_w;
    logic [7:0]      x8, y8;
    logic [23:0]     bar_rgb, pixel;

    assign running     = (state_q != IDLE);
    assign tick        = running && (div_q == DW'(CLKEN_DIV - 1));
    assign h_last      = (h_q == HW'(H_TOTAL - 1));
    assign v_last      = (v_q == VW'(V_TOTAL - 1));
    assign frame_end   = tick && h_last && v_last;
    assign vsync_w     = running && (int'(v_q) < V_SYNC);
    assign active_line = running && (int'(v_q) >= V_ACT0) && (int'(v_q) < V_ACT1);
    assign href_w      = active_line && (int'(h_q) < H_ACTIVE);
    assign x8          = 8'(h_q);
    // Only meaningful on active lines, where v_q >= V_ACT0.
    assign y8          = 8'(v_q - VW'(V_ACT0));

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx_q)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pixel = solid_q;
        case (pat_q)
            2'd0: pixel = bar_rgb;
            2'd1: pixel = {x8, y8, x8 + y8};
            2'd2: pixel = (x8[5] ^ y8[5]) ? 24'hFFFFFF : 24'h000000;
            default: pixel = solid_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        h_d         = h_q;
        v_d         = v_q;
        bar_px_d    = bar_px_q;
        bar_idx_d   = bar_idx_q;
        pat_d       = pat_q;
        solid_d     = solid_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                div_d     = '0;
                h_d       = '0;
                v_d       = '0;
                bar_px_d  = '0;
                bar_idx_d = '0;
                if (enable) begin
                    state_d = RUN;
                    pat_d   = pattern_sel;
                    solid_d = solid_rgb;
                end
            end
            default: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    // Bar index tracks x / BW incrementally, saturating on the last bar.
                    if (href_w) begin
                        if (bar_px_q == BCW'(BW - 1)) begin
                            bar_px_d = '0;
                            if (bar_idx_q != 3'd7)
                                bar_idx_d = bar_idx_q + 1'b1;
                        end else begin
                            bar_px_d = bar_px_q + 1'b1;
                        end
                    end
                    if (h_last) begin
                        h_d       = '0;
                        bar_px_d  = '0;
                        bar_idx_d = '0;
                        v_d       = v_last ? '0 : v_q + 1'b1;
                    end else begin
                        h_d = h_q + 1'b1;
                    end
                end
                if (state_q == RUN && !enable && !frame_end)
                    state_d = DRAIN;
                if (frame_end) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (state_q == RUN && enable) begin
                        pat_d   = pattern_sel;
                        solid_d = solid_rgb;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            bar_px_q    <= '0;
            bar_idx_q   <= '0;
            pat_q       <= '0;
            solid_q     <= '0;
            frame_cnt_q <= '0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            clken_q     <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            h_q         <= h_d;
            v_q         <= v_d;
            bar_px_q    <= bar_px_d;
            bar_idx_q   <= bar_idx_d;
            pat_q       <= pat_d;
            solid_q     <= solid_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_w;
            href_q      <= href_w;
            clken_q     <= tick && href_w;
            data_q      <= (tick && href_w) ? pixel : 24'h000000;
            done_q      <= frame_end;
        end
    end

    assign post_frame_vsync = vsync_q;
    assign post_frame_href  = href_q;
    assign post_frame_clken = clken_q;
    assign post_frame_data  = data_q;
    assign frame_done       = done_q;
    assign frame_cnt        = frame_cnt_q;
endmodule
